// File: rtl/cgra_ctrl_loader_if.sv
// cgra_ctrl_loader_if: en/rdy/msg transfer bundle for the loader's ports.
// en and msg are driven by the master side; rdy comes back from the slave side.
interface cgra_ctrl_loader_if #(
    parameter int EN_W  = 1,
    parameter int MSG_W = 1
) ();
    logic [EN_W-1:0]  en;
    logic [MSG_W-1:0] msg;
    logic [EN_W-1:0]  rdy;

    modport master (output en, output msg, input rdy);
    modport slave  (input en, input msg, output rdy);
endinterface

// File: rtl/cgra_ctrl_loader.sv
// cgra_ctrl_loader: buffers control-word records and writes each into its
// target tile's ctrl_mem through the waddr/wopt ports, then flags completion.
module cgra_ctrl_loader #(
    parameter int NUM_TILES  = 16,
    parameter int CTRL_DEPTH = 8,
    parameter int CFG_W      = 49,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 8,
    localparam int TW = $clog2(NUM_TILES),
    localparam int AW = $clog2(CTRL_DEPTH),
    localparam int MW = 1 + TW + AW + CFG_W,
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    cgra_ctrl_loader_if.slave  recv_cfg,
    cgra_ctrl_loader_if.master send_waddr,
    cgra_ctrl_loader_if.master send_wopt,
    output logic               cfg_done,
    output logic [CNT_W-1:0]   cfg_count,
    output logic               cfg_err
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [MW-1:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_fill;
    logic             r_wa_sent;
    logic             r_wo_sent;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [MW-1:0]        w_head;
    logic [TW-1:0]        w_tile;
    logic [AW-1:0]        w_addr;
    logic [CFG_W-1:0]     w_cfg;
    logic                 w_hv;
    logic                 w_full;
    logic                 w_tile_ok;
    logic [NUM_TILES-1:0] w_sel;
    logic                 w_wa_go;
    logic                 w_wo_go;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rdy;
    logic                 w_clr;

    assign w_head = r_mem[r_rptr];
    assign w_tile = w_head[CFG_W+AW +: TW];
    assign w_addr = w_head[CFG_W +: AW];
    assign w_cfg  = w_head[CFG_W-1:0];
    assign w_hv   = (r_fill != '0);
    assign w_full = (r_fill == (PW+1)'(FIFO_DEPTH));

    // Out-of-range tiles select nothing and simply retire.
    assign w_tile_ok = w_hv && (32'(w_tile) < NUM_TILES);
    assign w_sel     = w_tile_ok
                     ? ({{(NUM_TILES-1){1'b0}}, 1'b1} << w_tile)
                     : '0;

    assign w_wa_go = w_hv & ~r_wa_sent & (|(w_sel & send_waddr.rdy));
    assign w_wo_go = w_hv & ~r_wo_sent & (|(w_sel & send_wopt.rdy));

    assign w_pop = w_hv & (~w_tile_ok
                 | ((r_wa_sent | w_wa_go) & (r_wo_sent | w_wo_go)));
    assign w_push = recv_cfg.en & w_rdy;

    assign send_waddr.en  = w_wa_go ? w_sel : '0;
    assign send_wopt.en   = w_wo_go ? w_sel : '0;
    assign send_waddr.msg = w_hv ? w_addr : '0;
    assign send_wopt.msg  = w_hv ? w_cfg : '0;
    assign recv_cfg.rdy   = w_rdy;

    assign cfg_done  = (r_state == S_DONE);
    assign cfg_count = r_count;
    assign cfg_err   = r_err;

    always_comb begin
        w_next = r_state;
        w_rdy  = 1'b0;
        w_clr  = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next = S_LOAD;
                    w_clr  = 1'b1;
                end
            end
            S_LOAD: begin
                // A full buffer still accepts when its head retires.
                w_rdy = ~w_full | w_pop;
                if (recv_cfg.en & w_rdy & recv_cfg.msg[MW-1])
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!w_hv)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fill    <= '0;
            r_wa_sent <= 1'b0;
            r_wo_sent <= 1'b0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_fill <= r_fill + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_pop) begin
                r_wa_sent <= 1'b0;
                r_wo_sent <= 1'b0;
            end else begin
                if (w_wa_go)
                    r_wa_sent <= 1'b1;
                if (w_wo_go)
                    r_wo_sent <= 1'b1;
            end
            if (w_clr)
                r_count <= '0;
            else if (w_pop && w_tile_ok && !(&r_count))
                r_count <= r_count + 1'b1;
            if (w_clr)
                r_err <= 1'b0;
            else if (w_pop && !w_tile_ok)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= recv_cfg.msg;
    end
endmodule
